gradient_accum_bank: RTL and testbench

- Multi-channel successor to the single-register gradient holder.
- Holds NUM_GRADS signed Q-format gradient accumulators and sums streamed per-sample gradient writes over a mini-batch of 2^BATCH_LOG2 samples.
- When the batch completes, streams out the per-index batch mean, then auto-clears for the next batch.
- Sits between the backprop datapath (producer) and the weight-update unit (consumer).

---
 rtl/gradient_accum_bank.sv | 192 +++++++++++++++++++
 tb/tb_gradient_accum_bank.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_accum_bank.sv
// ---------------------------------------------------------------------------
// gradient_accum_bank
//
// Bank of NUM_GRADS signed Q-format gradient accumulators. Per-sample gradient
// beats from the backprop datapath are summed (saturating) into the selected
// accumulator. After 2^BATCH_LOG2 samples, the bank drains one batch mean per
// index to the weight-update unit. It then clears itself for the next batch.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear_en     synchronous clear of accumulators, counter and FSM (wins
//                over every other input)
//   in_valid     gradient beat valid            in_ready   bank accepts beats
//   in_idx       target accumulator             in_data    signed gradient
//   in_last      beat closes the current sample
//   out_valid    batch mean valid               out_ready  consumer accepts
//   out_idx      index of out_data              out_data   signed batch mean
//   batch_done   one-cycle pulse after the final mean is accepted
//   sat_flag     sticky: some accumulator saturated during this batch
//
// Handshake: both ports use valid/ready. A beat transfers on a rising edge
// where valid && ready. Once valid is raised, the producer holds the payload
// until that transfer. The bank never makes valid depend on ready. A beat
// presented while clear_en is high is discarded, even if valid && ready.
// ---------------------------------------------------------------------------
module gradient_accum_bank #(
    parameter int FIXED_BITS      = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int NUM_GRADS       = 4,
    parameter int BATCH_LOG2      = 2,
    localparam int W  = FIXED_BITS + FRACTIONAL_BITS,
    localparam int AW = W + BATCH_LOG2,
    localparam int IW = $clog2(NUM_GRADS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output logic [W-1:0]  out_data,
    output logic          batch_done,
    output logic          sat_flag
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [AW-1:0] ACC_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN  = {1'b1, {(AW-1){1'b0}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_GRADS - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         acc_q [NUM_GRADS];
    logic [AW-1:0]         acc_d [NUM_GRADS];
    logic [BATCH_LOG2-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         drain_idx_q, drain_idx_d;
    logic                  sat_q, sat_d;
    logic                  done_q, done_d;

    logic                  wr_fire;
    logic                  out_fire;
    logic                  idx_ok;
    logic [AW-1:0]         acc_sel;
    logic [AW-1:0]         acc_out;
    logic [AW:0]           sum_ext;
    logic                  sum_ovf;
    logic [AW-1:0]         wr_sum;

    // Output decode
    always_comb begin
        in_ready   = (state_q == ST_ACCUM);
        out_valid  = (state_q == ST_DRAIN);
        out_idx    = drain_idx_q;
        acc_out    = acc_q[drain_idx_q];
        // Because AW == W + BATCH_LOG2, the top W bits of the accumulator are
        // exactly acc >>> BATCH_LOG2. That is the floor of the mean, and it
        // always fits in W bits.
        out_data   = out_valid ? acc_out[AW-1:BATCH_LOG2] : '0;
        batch_done = done_q;
        sat_flag   = sat_q;
    end

    // Saturating add of the sign-extended beat into the selected accumulator
    always_comb begin
        wr_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        idx_ok   = ({1'b0, in_idx} < (IW+1)'(NUM_GRADS));
        acc_sel  = idx_ok ? acc_q[in_idx] : '0;
        sum_ext  = {acc_sel[AW-1], acc_sel} + {{(AW+1-W){in_data[W-1]}}, in_data};
        // Overflow shows up as the two top bits of the extended sum disagreeing.
        sum_ovf  = sum_ext[AW] ^ sum_ext[AW-1];
        if (sum_ovf) begin
            wr_sum = sum_ext[AW] ? ACC_MIN : ACC_MAX;
        end else begin
            wr_sum = sum_ext[AW-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_idx_d = drain_idx_q;
        sat_d       = sat_q;
        done_d      = 1'b0;
        for (int i = 0; i < NUM_GRADS; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (clear_en) begin
            state_d     = ST_ACCUM;
            cnt_d       = '0;
            drain_idx_d = '0;
            sat_d       = 1'b0;
            for (int i = 0; i < NUM_GRADS; i++) begin
                acc_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (wr_fire) begin
                        // Out-of-range indices drop the data, but in_last still counts.
                        if (idx_ok) begin
                            acc_d[in_idx] = wr_sum;
                            if (sum_ovf) begin
                                sat_d = 1'b1;
                            end
                        end
                        if (in_last) begin
                            if (cnt_q == '1) begin
                                cnt_d       = '0;
                                drain_idx_d = '0;
                                state_d     = ST_DRAIN;
                            end else begin
                                cnt_d = cnt_q + BATCH_LOG2'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (drain_idx_q == LAST_IDX) begin
                            state_d     = ST_ACCUM;
                            drain_idx_d = '0;
                            sat_d       = 1'b0;
                            done_d      = 1'b1;
                            for (int i = 0; i < NUM_GRADS; i++) begin
                                acc_d[i] = '0;
                            end
                        end else begin
                            drain_idx_d = drain_idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            drain_idx_q <= '0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < NUM_GRADS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_idx_q <= drain_idx_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
            for (int i = 0; i < NUM_GRADS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gradient_accum_bank.sv
// ---------------------------------------------------------------------------
// tb_gradient_accum_bank
//
// Drives gradient beats into gradient_accum_bank and keeps a behavioural model
// of the batch sums in plain integers. The model pushes the expected
// {sat_flag, out_idx, out_data} of every completed batch into exp_q. A separate
// monitor compares each presented mean against the queue head. It pops the
// head whenever the consumer accepts that mean.
// ---------------------------------------------------------------------------
module tb_gradient_accum_bank;

    localparam int W   = 16;
    localparam int NG  = 4;
    localparam int BL  = 2;
    localparam int IW  = 2;
    localparam int AW  = W + BL;
    localparam int ACC_HI = (1 << (AW - 1)) - 1;
    localparam int ACC_LO = -(1 << (AW - 1));

    logic          clk;
    logic          rst_n;
    logic          clear_en;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [W-1:0]  out_data;
    logic          batch_done;
    logic          sat_flag;

    gradient_accum_bank #(
        .FIXED_BITS(8), .FRACTIONAL_BITS(8), .NUM_GRADS(NG), .BATCH_LOG2(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear_en(clear_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .batch_done(batch_done), .sat_flag(sat_flag)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [IW+W:0] exp_q[$];
    logic [IW+W:0] mon_e;
    int            m_acc[NG];
    int            m_cnt;
    bit            m_sat;
    bit            done_expect;
    bit            rdy_mode;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NG; i++) m_acc[i] = 0;
        m_cnt = 0;
        m_sat = 1'b0;
    endfunction

    // Behavioural model: saturating integer sums, floor mean via integer shift
    function automatic void model_write(int idx, logic [W-1:0] d, bit last);
        int s;
        int mean;
        logic [W-1:0] mean_w;
        logic [IW-1:0] iw;
        if (idx < NG) begin
            s = m_acc[idx] + int'($signed(d));
            if (s > ACC_HI) begin s = ACC_HI; m_sat = 1'b1; end
            else if (s < ACC_LO) begin s = ACC_LO; m_sat = 1'b1; end
            m_acc[idx] = s;
        end
        if (last) begin
            m_cnt++;
            if (m_cnt == (1 << BL)) begin
                for (int i = 0; i < NG; i++) begin
                    mean   = m_acc[i] >>> BL;
                    mean_w = mean[W-1:0];
                    iw     = i[IW-1:0];
                    exp_q.push_back({m_sat, iw, mean_w});
                end
                model_clear();
            end
        end
    endfunction

    // ---------------- driver tasks (entered at posedge + #1) ----------------
    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(int idx, logic [W-1:0] d, bit last);
        int t = 0;
        in_valid = 1'b1;
        in_idx   = idx[IW-1:0];
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && t < 500) begin @(negedge clk); t++; end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
            model_write(idx, d, last);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_q_size(int n);
        int t = 0;
        while (exp_q.size() != n && t < 500) begin idle(1); t++; end
        chk("wait_q_size", exp_q.size(), n);
    endtask

    task automatic drain();
        wait_q_size(0);
        idle(2);
    endtask

    // ---------------- out_ready randomiser ----------------
    always @(posedge clk) begin
        if (rdy_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            done_expect = 1'b0;
        end else begin
            if (done_expect || batch_done) begin
                chk("batch_done", int'(batch_done), int'(done_expect));
                chk("sat_after_done", int'(sat_flag), 0);
            end
            done_expect = 1'b0;
            if (out_valid) begin
                chk("in_ready_in_drain", int'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = exp_q[0];
                    chk("out_idx", int'(out_idx), int'(mon_e[W+IW-1:W]));
                    chk("out_data", int'(out_data), int'(mon_e[W-1:0]));
                    chk("sat_flag", int'(sat_flag), int'(mon_e[W+IW]));
                    if (out_ready && !clear_en) begin
                        void'(exp_q.pop_front());
                        if (mon_e[W+IW-1:W] == IW'(NG - 1)) done_expect = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; clear_en = 1'b0; in_valid = 1'b0; in_idx = '0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1; rdy_mode = 1'b0;
        done_expect = 1'b0;
        model_clear();
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_done", int'(batch_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Mean of a constant
        for (int i = 0; i < 4; i++) send(0, 16'h0100, 1'b1);
        drain();
        chk("mean_in_ready_after", int'(in_ready), 1);

        // Rounding toward -inf
        for (int i = 0; i < 3; i++) send(1, 16'hFFFF, 1'b1);
        send(1, 16'h0000, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) send(1, 16'hFFFD, 1'b1);
        drain();

        // Saturation
        for (int i = 0; i < 7; i++) send(2, 16'h7FFF, 1'b0);
        send(2, 16'h7FFF, 1'b1);
        chk("sat_set", int'(sat_flag), 1);
        for (int i = 0; i < 3; i++) send(0, 16'h0000, 1'b1);
        drain();
        chk("sat_cleared", int'(sat_flag), 0);

        // Backpressure at index 1
        for (int i = 0; i < 4; i++) send(1, 16'h0200, 1'b1);
        wait_q_size(3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("bp_hold_idx", int'(out_idx), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        drain();

        // Clear wins during DRAIN at index 1
        for (int i = 0; i < 4; i++) send(2, 16'h0500, 1'b1);
        wait_q_size(3);
        clear_en = 1'b1;
        idle(1);
        clear_en = 1'b0;
        exp_q.delete();
        model_clear();
        chk("clr_out_valid", int'(out_valid), 0);
        chk("clr_in_ready", int'(in_ready), 1);
        idle(2);
        for (int i = 0; i < 4; i++) send(3, 16'h0040, 1'b1);
        drain();

        // Randomised beats with random consumer stalls
        rdy_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            send(int'($urandom_range(0, NG - 1)), 16'($urandom), ($urandom_range(0, 2) == 0));
        end
        while (m_cnt != 0) send(0, 16'($urandom_range(0, 255)), 1'b1);
        drain();
        rdy_mode = 1'b0;
        idle(1);
        out_ready = 1'b1;

        // Asynchronous reset mid-DRAIN with sat_flag set
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(2, 16'h7FFF, 1'b0);
        for (int i = 0; i < 4; i++) send(0, 16'h0000, 1'b1);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_sat", int'(sat_flag), 0);
        chk("arst_done", int'(batch_done), 0);
        exp_q.delete();
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 16'h0010, 1'b1);
        drain();

        idle(3);
        chk("leftover_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
